mul_div_unit: RTL and testbench

//   Iterative multiply/divide unit for the 5-stage pipeline EX stage. Parametrised successor to the 32-bit adder.

---
 rtl/mul_div_pkg.sv | 18 +
 rtl/mul_div_if.sv | 24 ++
 rtl/mul_div_unit_addsub_core.sv | 18 +
 rtl/mul_div_unit.sv | 181 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mul_div_if.sv
// Start/busy/done request bus between the EX stage (master) and the multiply/divide unit (slave).
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit_addsub_core.sv
// Parametrised adder/subtractor; with i_sub=1 computes i_x - i_y and o_cout=1 means i_x >= i_y.
module addsub_core #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH-1:0] w_y_inv;
  logic [WIDTH:0]   w_full;

  assign w_y_inv = i_y ^ {WIDTH{i_sub}};
  assign w_full  = {1'b0, i_x} + {1'b0, w_y_inv} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH-1:0];
  assign o_cout  = w_full[WIDTH];
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit, one add/subtract step per clock.
// Define MUL_DIV_SIGNED_EN to honour op[0] as a signed select; otherwise every operation is unsigned.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  mul_div_if.slave s
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz_out;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Working registers: acc_hi is the product upper half / partial remainder,
  // acc_lo the multiplier shifting out / quotient shifting in.
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;
  logic             r_dbz;

  logic             w_start_div;
  logic             w_start_dbz;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic             w_cout;
  logic [WIDTH:0]   w_mul_part;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_start_div = (s.op == OP_DIVU) || (s.op == OP_DIV);
  assign w_start_dbz = w_start_div && (s.b == '0);

`ifdef MUL_DIV_SIGNED_EN
  logic w_start_sgn;
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;
  logic w_hi_neg;
  logic w_hi_cin;

  assign w_start_sgn = (s.op == OP_MULT) || (s.op == OP_DIV);
  assign w_a_neg     = w_start_sgn & s.a[WIDTH-1];
  assign w_b_neg     = w_start_sgn & s.b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (~s.a + WIDTH'(1)) : s.a;
  assign w_b_mag     = w_b_neg ? (~s.b + WIDTH'(1)) : s.b;

  // Lo negation goes through the shared adder; hi only needs an increment of its complement,
  // carrying in from lo for a 2*WIDTH product and always for a remainder.
  assign w_hi_neg = r_is_div ? r_neg_r : r_neg_q;
  assign w_hi_cin = r_is_div || (r_acc_lo == '0);
  assign w_fix_lo = r_neg_q ? w_sum[WIDTH-1:0] : r_acc_lo;
  assign w_fix_hi = w_hi_neg ? (~r_acc_hi + WIDTH'(w_hi_cin)) : r_acc_hi;
`else
  assign w_a_mag  = s.a;
  assign w_b_mag  = s.b;
  assign w_fix_lo = r_acc_lo;
  assign w_fix_hi = r_acc_hi;
`endif

  always_comb begin
    w_x   = '0;
    w_y   = {1'b0, r_acc_lo};
    w_sub = 1'b1;
    if (r_state == S_RUN) begin
      w_y = {1'b0, r_opnd};
      if (r_is_div) begin
        w_x = {r_acc_hi, r_acc_lo[WIDTH-1]};
      end else begin
        w_x   = {1'b0, r_acc_hi};
        w_sub = 1'b0;
      end
    end
  end

  addsub_core #(
    .WIDTH(WIDTH + 1)
  ) u_addsub (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_sub (w_sub),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  assign w_mul_part = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};
  assign w_div_rem  = w_cout ? w_sum[WIDTH-1:0] : {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
  // For a zero divisor acc_lo still holds the raw dividend.
  assign w_res_lo   = r_dbz ? '1 : w_fix_lo;
  assign w_res_hi   = r_dbz ? r_acc_lo : w_fix_hi;

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE, S_DONE: begin
        if (s.start) begin
          r_is_div <= w_start_div;
          r_dbz    <= w_start_dbz;
          r_acc_hi <= '0;
          r_acc_lo <= w_start_dbz ? s.a : (w_start_div ? w_a_mag : w_b_mag);
          r_opnd   <= w_start_div ? w_b_mag : w_a_mag;
`ifdef MUL_DIV_SIGNED_EN
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg;
`endif
        end
      end
      S_RUN: begin
        if (r_is_div) begin
          r_acc_hi <= w_div_rem;
          r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_cout};
        end else begin
          r_acc_hi <= w_mul_part[WIDTH:1];
          r_acc_lo <= {w_mul_part[0], r_acc_lo[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (s.start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= w_start_dbz ? S_FIX : S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi      <= w_res_hi;
          r_lo      <= w_res_lo;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_dbz_out <= r_dbz;
          r_state   <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s.busy        = r_busy;
  assign s.done        = r_done;
  assign s.hi          = r_hi;
  assign s.lo          = r_lo;
  assign s.div_by_zero = r_dbz_out;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected HI/LO/div_by_zero plus latency checks.
module tb_mul_div_unit;
  localparam int W = 32;

  typedef struct packed {
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .s    (bus)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    logic        sgn;
`ifdef MUL_DIV_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    e.dbz = 1'b0;
    if (!op[1]) begin
      if (sgn) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else     p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.dbz = 1'b1;
      e.hi  = a;
      e.lo  = '1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = a;
        e.hi = '0;
      end else begin
        e.lo = $signed(a) / $signed(b);
        e.hi = $signed(a) % $signed(b);
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Drives a one-cycle start from the current negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input bit push);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts posedges since the start edge (the start edge itself is clock 1) until done is seen.
  task automatic wait_done(input int cyc0, output int cyc, output bit ok);
    cyc = cyc0;
    ok  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    checks++; if (bus.hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
  endtask

  task automatic test_multiply();
    logic [1:0]   ops[2];
    logic [W-1:0] as[2];
    logic [W-1:0] bs[2];
    exp_t         exps[2];
    exp_t         e;
    int           cyc;
    bit           ok;
    ops = '{2'b00, 2'b01};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    bs  = '{32'hFFFF_FFFF, 32'd7};
    exps[0] = exp_t'{1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
`ifdef MUL_DIV_SIGNED_EN
    exps[1] = exp_t'{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
`else
    exps[1] = exp_t'{1'b0, 32'h0000_0006, 32'hFFFF_FFEB};
`endif
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], as[i], bs[i], exps[i], 1'b1);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul%0d_busy: got %b expected 1", i, bus.busy); end
      wait_done(1, cyc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mul%0d_timeout: got no done expected done", i); end
      else if (cyc != 34) begin errors++; $display("FAIL mul%0d_latency: got %0d expected 34", i, cyc); end
      e = sb_q.pop_front();
      checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL mul%0d_hi: got %h expected %h", i, bus.hi, e.hi); end
      checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL mul%0d_lo: got %h expected %h", i, bus.lo, e.lo); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul%0d_pulse: got %b expected 0", i, bus.done); end
    end
  endtask

  task automatic test_divide();
    logic [1:0]   ops[4];
    logic [W-1:0] as[4];
    logic [W-1:0] bs[4];
    exp_t         exps[4];
    exp_t         e;
    int           cyc;
    bit           ok;
    ops = '{2'b10, 2'b11, 2'b11, 2'b11};
    as  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    bs  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    exps[0] = exp_t'{1'b0, 32'd2, 32'd14};
`ifdef MUL_DIV_SIGNED_EN
    exps[1] = exp_t'{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    exps[2] = exp_t'{1'b0, 32'h0000_0000, 32'h8000_0000};
    exps[3] = exp_t'{1'b0, 32'h0000_0001, 32'hFFFF_FFFD};
`else
    exps[1] = exp_t'{1'b0, 32'h0000_0001, 32'h7FFF_FFFC};
    exps[2] = exp_t'{1'b0, 32'h8000_0000, 32'h0000_0000};
    exps[3] = exp_t'{1'b0, 32'h0000_0007, 32'h0000_0000};
`endif
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], exps[i], 1'b1);
      wait_done(1, cyc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL div%0d_timeout: got no done expected done", i); end
      else if (cyc != 34) begin errors++; $display("FAIL div%0d_latency: got %0d expected 34", i, cyc); end
      e = sb_q.pop_front();
      checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, bus.lo, e.lo); end
      checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, bus.hi, e.hi); end
      checks++; if (bus.div_by_zero !== e.dbz) begin errors++; $display("FAIL div%0d_dbz: got %b expected %b", i, bus.div_by_zero, e.dbz); end
    end
  endtask

  task automatic test_div_zero();
    logic [1:0]   ops[2];
    logic [W-1:0] as[2];
    exp_t         e;
    int           cyc;
    bit           ok;
    ops = '{2'b10, 2'b11};
    as  = '{32'h0000_1234, 32'hFFFF_FFFB};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], as[i], '0, exp_t'{1'b1, as[i], 32'hFFFF_FFFF}, 1'b1);
      wait_done(1, cyc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL dbz%0d_timeout: got no done expected done", i); end
      else if (cyc != 2) begin errors++; $display("FAIL dbz%0d_latency: got %0d expected 2", i, cyc); end
      e = sb_q.pop_front();
      checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL dbz%0d_lo: got %h expected %h", i, bus.lo, e.lo); end
      checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL dbz%0d_hi: got %h expected %h", i, bus.hi, e.hi); end
      checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz%0d_flag: got %b expected 1", i, bus.div_by_zero); end
      @(negedge clk);
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz%0d_flag_pulse: got %b expected 0", i, bus.div_by_zero); end
    end
  endtask

  task automatic test_busy_and_abort();
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;
    exp_t         e;
    int           cyc;
    bit           ok;
    bit           seen;
    prev_hi = bus.hi;
    prev_lo = bus.lo;
    issue(2'b00, 32'd6, 32'd7, exp_t'{1'b0, 32'd0, 32'd42}, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.hi !== prev_hi || bus.lo !== prev_lo) begin
      errors++; $display("FAIL ign_hold: got %h_%h expected %h_%h", bus.hi, bus.lo, prev_hi, prev_lo);
    end
    issue(2'b00, 32'd1, 32'd1, exp_t'{1'b0, 32'd0, 32'd1}, 1'b0);
    wait_done(6, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_timeout: got no done expected done"); end
    else if (cyc != 34) begin errors++; $display("FAIL ign_latency: got %0d expected 34", cyc); end
    e = sb_q.pop_front();
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL ign_hi: got %h expected %h", bus.hi, e.hi); end
    checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL ign_lo: got %h expected %h", bus.lo, e.lo); end

    @(negedge clk);
    issue(2'b00, 32'd3, 32'd5, exp_t'{1'b0, 32'd0, 32'd15}, 1'b1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== '0 || bus.lo !== '0) begin
      errors++; $display("FAIL abort_hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bit   ok;
    issue(2'b10, 32'd100, 32'd7, exp_t'{1'b0, 32'd2, 32'd14}, 1'b1);
    wait_done(1, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no done expected done"); end
    e = sb_q.pop_front();
    checks++; if (bus.lo !== e.lo || bus.hi !== e.hi) begin
      errors++; $display("FAIL b2b_first: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo);
    end
    issue(2'b10, 32'd9, 32'd4, exp_t'{1'b0, 32'd1, 32'd2}, 1'b1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", bus.busy); end
    wait_done(1, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got no done expected done"); end
    else if (cyc != 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", cyc); end
    e = sb_q.pop_front();
    checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL b2b_lo: got %h expected %h", bus.lo, e.lo); end
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL b2b_hi: got %h expected %h", bus.hi, e.hi); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    int           cyc;
    int           lat;
    bit           ok;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (i == 3)          b = '0;
      else if (i % 2 == 0) b = $urandom;
      else                 b = $urandom_range(1, 50);
      issue(op, a, b, model(op, a, b), 1'b1);
      lat = (op[1] && b == 0) ? 2 : 34;
      wait_done(1, cyc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd%0d_timeout: got no done expected done", i); end
      else if (cyc != lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, cyc, lat); end
      e = sb_q.pop_front();
      checks++; if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== e.dbz) begin
        errors++;
        $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %b_%h_%h expected %b_%h_%h", i, op, a, b,
                 bus.div_by_zero, bus.hi, bus.lo, e.dbz, e.hi, e.lo);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_busy_and_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
